// File: rtl/encode.sv
// ---------------------------------------------------------------------------
// encode : transmit-side UDT packet builder.
//
// Arbitrates among pending packet requests (Handshake > ACK2 > ACK > NAK >
// Keep_live > Data) and emits one UDT packet at a time on an AXI-Stream
// toward the UDP layer: a 4-word header, then either the control body or the
// data payload streamed straight through from the sender buffer.
//
// Optional feature macro: UDT_LIGHT_ACK_EN
//   When defined, an extra input ack_light selects a light ACK whose body is
//   rcv_next_seq only (5-beat packet). When undefined every ACK is 8 beats.
//
// Ports
//   core_clk, core_rst_n         clock, asynchronous active-low reset
//   timestamp, dst_sock_id       common header fields, sampled at grant
//   Data_req / Data_ack          data packet request / done pulse
//   seq_no, msg_ctl, msg_no      data header fields
//   in_t*                        payload stream from the sender buffer
//   ACK_req / ACK_ack            ACK request (ack_seq_no, rcv_next_seq, rtt,
//                                rtt_var, avail_buf)
//   ACK2_req / ACK2_ack          ACK2 request (ack_seq_no)
//   NAK_req / NAK_ack            NAK request (nak_first, nak_last)
//   Keep_live_req / _ack         keep-alive request
//   Handshake_req / _ack         handshake request (hs_info, MSB word first)
//   out_t*                       packet stream toward UDP
// ---------------------------------------------------------------------------
module encode #(
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                              core_clk,
  input  logic                              core_rst_n,
  input  logic [31:0]                       timestamp,
  input  logic [31:0]                       dst_sock_id,
  input  logic                              Data_req,
  output logic                              Data_ack,
  input  logic [30:0]                       seq_no,
  input  logic [2:0]                        msg_ctl,
  input  logic [28:0]                       msg_no,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     in_tdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   in_tkeep,
  input  logic                              in_tvalid,
  output logic                              in_tready,
  input  logic                              in_tlast,
  input  logic                              ACK_req,
  output logic                              ACK_ack,
  input  logic [31:0]                       ack_seq_no,
  input  logic [31:0]                       rcv_next_seq,
  input  logic [31:0]                       rtt,
  input  logic [31:0]                       rtt_var,
  input  logic [31:0]                       avail_buf,
  input  logic                              ACK2_req,
  output logic                              ACK2_ack,
  input  logic                              NAK_req,
  output logic                              NAK_ack,
  input  logic [30:0]                       nak_first,
  input  logic [30:0]                       nak_last,
  input  logic                              Keep_live_req,
  output logic                              Keep_live_ack,
  input  logic                              Handshake_req,
  output logic                              Handshake_ack,
  input  logic [255:0]                      hs_info,
`ifdef UDT_LIGHT_ACK_EN
  input  logic                              ack_light,
`endif
  output logic [C_S_AXI_DATA_WIDTH-1:0]     out_tdata,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   out_tkeep,
  output logic                              out_tvalid,
  output logic                              out_tlast,
  input  logic                              out_tready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR     = 3'd1,
    S_BODY    = 3'd2,
    S_PAYLOAD = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  // One-hot requester selects, bit order matches the ack output packing.
  localparam logic [5:0] SEL_HS   = 6'b100000;
  localparam logic [5:0] SEL_ACK2 = 6'b010000;
  localparam logic [5:0] SEL_ACK  = 6'b001000;
  localparam logic [5:0] SEL_NAK  = 6'b000100;
  localparam logic [5:0] SEL_KA   = 6'b000010;
  localparam logic [5:0] SEL_DATA = 6'b000001;

  state_t      r_state;
  logic [31:0] r_words [0:11];
  logic [3:0]  r_last_idx;
  logic [3:0]  r_idx;
  logic        r_is_data;
  logic [5:0]  r_sel;
  logic [5:0]  r_ack;
  logic [31:0] r_out_tdata;
  logic [3:0]  r_out_tkeep;
  logic        r_out_tvalid;
  logic        r_out_tlast;

  logic [5:0]  w_sel;
  logic [31:0] w_words [0:11];
  logic [3:0]  w_last_idx;
  logic        w_is_data;
  logic [3:0]  w_next_idx;
  logic        w_ack_light;
  logic        w_in_payload;

`ifdef UDT_LIGHT_ACK_EN
  assign w_ack_light = ack_light;
`else
  assign w_ack_light = 1'b0;
`endif

  assign w_next_idx   = r_idx + 4'd1;
  assign w_in_payload = (r_state == S_PAYLOAD);

  // Fixed-priority arbitration among pending requests.
  always_comb begin
    w_sel = 6'b000000;
    if (Handshake_req) begin
      w_sel = SEL_HS;
    end else if (ACK2_req) begin
      w_sel = SEL_ACK2;
    end else if (ACK_req) begin
      w_sel = SEL_ACK;
    end else if (NAK_req) begin
      w_sel = SEL_NAK;
    end else if (Keep_live_req) begin
      w_sel = SEL_KA;
    end else if (Data_req) begin
      w_sel = SEL_DATA;
    end else begin
      w_sel = 6'b000000;
    end
  end

  // Assemble header and body words of the winning request; latched at grant
  // so the requester may change its fields afterwards.
  always_comb begin
    for (int k = 0; k < 12; k++) begin
      w_words[k] = 32'h0000_0000;
    end
    w_last_idx = 4'd3;
    w_is_data  = 1'b0;
    w_words[2] = timestamp;
    w_words[3] = dst_sock_id;
    case (w_sel)
      SEL_HS: begin
        w_words[0]  = {1'b1, 15'd0, 16'h0000};
        w_words[4]  = hs_info[255:224];
        w_words[5]  = hs_info[223:192];
        w_words[6]  = hs_info[191:160];
        w_words[7]  = hs_info[159:128];
        w_words[8]  = hs_info[127:96];
        w_words[9]  = hs_info[95:64];
        w_words[10] = hs_info[63:32];
        w_words[11] = hs_info[31:0];
        w_last_idx  = 4'd11;
      end
      SEL_ACK2: begin
        w_words[0] = {1'b1, 15'd6, 16'h0000};
        w_words[1] = ack_seq_no;
      end
      SEL_ACK: begin
        w_words[0] = {1'b1, 15'd2, 16'h0000};
        w_words[1] = ack_seq_no;
        w_words[4] = rcv_next_seq;
        w_words[5] = rtt;
        w_words[6] = rtt_var;
        w_words[7] = avail_buf;
        w_last_idx = w_ack_light ? 4'd4 : 4'd7;
      end
      SEL_NAK: begin
        w_words[0] = {1'b1, 15'd3, 16'h0000};
        // A single lost packet is one word with flag 0; a range sets the
        // flag on the first word.
        if (nak_first == nak_last) begin
          w_words[4] = {1'b0, nak_first};
          w_last_idx = 4'd4;
        end else begin
          w_words[4] = {1'b1, nak_first};
          w_words[5] = {1'b0, nak_last};
          w_last_idx = 4'd5;
        end
      end
      SEL_KA: begin
        w_words[0] = {1'b1, 15'd1, 16'h0000};
      end
      SEL_DATA: begin
        w_words[0] = {1'b0, seq_no};
        w_words[1] = {msg_ctl, msg_no};
        w_is_data  = 1'b1;
      end
      default: begin
        w_last_idx = 4'd3;
      end
    endcase
  end

  // Packet FSM with registered header/body beats and ack pulse.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      r_state      <= S_IDLE;
      for (int k = 0; k < 12; k++) begin
        r_words[k] <= 32'h0000_0000;
      end
      r_last_idx   <= 4'd0;
      r_idx        <= 4'd0;
      r_is_data    <= 1'b0;
      r_sel        <= 6'b000000;
      r_ack        <= 6'b000000;
      r_out_tdata  <= 32'h0000_0000;
      r_out_tkeep  <= 4'h0;
      r_out_tvalid <= 1'b0;
      r_out_tlast  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ack <= 6'b000000;
          if (w_sel != 6'b000000) begin
            r_words      <= w_words;
            r_last_idx   <= w_last_idx;
            r_is_data    <= w_is_data;
            r_sel        <= w_sel;
            r_idx        <= 4'd0;
            r_out_tdata  <= w_words[0];
            r_out_tkeep  <= 4'hF;
            r_out_tvalid <= 1'b1;
            r_out_tlast  <= 1'b0;
            r_state      <= S_HDR;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_HDR, S_BODY: begin
          if (out_tready) begin
            if (r_idx == r_last_idx) begin
              r_out_tvalid <= 1'b0;
              r_out_tlast  <= 1'b0;
              r_out_tkeep  <= 4'h0;
              r_out_tdata  <= 32'h0000_0000;
              if (r_is_data) begin
                r_state <= S_PAYLOAD;
              end else begin
                r_state <= S_DONE;
                r_ack   <= r_sel;
              end
            end else begin
              r_idx       <= w_next_idx;
              r_out_tdata <= r_words[w_next_idx];
              r_out_tlast <= (w_next_idx == r_last_idx) && !r_is_data;
              r_state     <= (w_next_idx >= 4'd4) ? S_BODY : S_HDR;
            end
          end else begin
            r_state <= r_state;
          end
        end
        S_PAYLOAD: begin
          if (in_tvalid && out_tready && in_tlast) begin
            r_state <= S_DONE;
            r_ack   <= r_sel;
          end else begin
            r_state <= S_PAYLOAD;
          end
        end
        S_DONE: begin
          r_ack   <= 6'b000000;
          r_state <= S_IDLE;
        end
        default: begin
          r_ack        <= 6'b000000;
          r_out_tvalid <= 1'b0;
          r_state      <= S_IDLE;
        end
      endcase
    end
  end

  // Payload beats pass straight through; everything else is registered.
  assign out_tdata  = w_in_payload ? in_tdata  : r_out_tdata;
  assign out_tkeep  = w_in_payload ? in_tkeep  : r_out_tkeep;
  assign out_tvalid = w_in_payload ? in_tvalid : r_out_tvalid;
  assign out_tlast  = w_in_payload ? in_tlast  : r_out_tlast;
  assign in_tready  = w_in_payload ? out_tready : 1'b0;

  assign Handshake_ack = r_ack[5];
  assign ACK2_ack      = r_ack[4];
  assign ACK_ack       = r_ack[3];
  assign NAK_ack       = r_ack[2];
  assign Keep_live_ack = r_ack[1];
  assign Data_ack      = r_ack[0];

endmodule

// File: tb/tb_encode.sv
// Scoreboard bench for encode: stimulus pushes expected beats/acks computed
// from the packet format rules; a negedge monitor pops and compares.
module tb_encode;

  localparam int K_HS = 0, K_KA = 1, K_ACK = 2, K_NAK = 3, K_ACK2 = 4, K_DATA = 5;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  logic core_rst_n;
  logic [31:0] timestamp, dst_sock_id;
  logic Data_req, ACK_req, ACK2_req, NAK_req, Keep_live_req, Handshake_req;
  logic Data_ack, ACK_ack, ACK2_ack, NAK_ack, Keep_live_ack, Handshake_ack;
  logic [30:0] seq_no;
  logic [2:0]  msg_ctl;
  logic [28:0] msg_no;
  logic [31:0] in_tdata;
  logic [3:0]  in_tkeep;
  logic in_tvalid, in_tready, in_tlast;
  logic [31:0] ack_seq_no, rcv_next_seq, rtt, rtt_var, avail_buf;
  logic [30:0] nak_first, nak_last;
  logic [255:0] hs_info;
`ifdef UDT_LIGHT_ACK_EN
  logic ack_light;
`endif
  logic [31:0] out_tdata;
  logic [3:0]  out_tkeep;
  logic out_tvalid, out_tlast, out_tready;

  wire [5:0] w_acks = {Handshake_ack, ACK2_ack, ACK_ack, NAK_ack, Keep_live_ack, Data_ack};

  encode #(.C_S_AXI_DATA_WIDTH(32)) dut (
    .core_clk(core_clk), .core_rst_n(core_rst_n),
    .timestamp(timestamp), .dst_sock_id(dst_sock_id),
    .Data_req(Data_req), .Data_ack(Data_ack),
    .seq_no(seq_no), .msg_ctl(msg_ctl), .msg_no(msg_no),
    .in_tdata(in_tdata), .in_tkeep(in_tkeep), .in_tvalid(in_tvalid),
    .in_tready(in_tready), .in_tlast(in_tlast),
    .ACK_req(ACK_req), .ACK_ack(ACK_ack), .ack_seq_no(ack_seq_no),
    .rcv_next_seq(rcv_next_seq), .rtt(rtt), .rtt_var(rtt_var), .avail_buf(avail_buf),
    .ACK2_req(ACK2_req), .ACK2_ack(ACK2_ack),
    .NAK_req(NAK_req), .NAK_ack(NAK_ack), .nak_first(nak_first), .nak_last(nak_last),
    .Keep_live_req(Keep_live_req), .Keep_live_ack(Keep_live_ack),
    .Handshake_req(Handshake_req), .Handshake_ack(Handshake_ack), .hs_info(hs_info),
`ifdef UDT_LIGHT_ACK_EN
    .ack_light(ack_light),
`endif
    .out_tdata(out_tdata), .out_tkeep(out_tkeep), .out_tvalid(out_tvalid),
    .out_tlast(out_tlast), .out_tready(out_tready)
  );

  int checks = 0;
  int errors = 0;
  int pkt_beats = 0;
  int rdy_mode = 0;
  beat_t exp_q[$];
  logic [5:0] exp_ack_q[$];
  logic [31:0] pay_d[0:7];
  logic [3:0]  pay_k[0:7];
  int pay_n = 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  function automatic logic [5:0] ack_bit(int kind);
    case (kind)
      K_HS:    return 6'b100000;
      K_ACK2:  return 6'b010000;
      K_ACK:   return 6'b001000;
      K_NAK:   return 6'b000100;
      K_KA:    return 6'b000010;
      K_DATA:  return 6'b000001;
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [31:0] ctl_word0(int code);
    return 32'h8000_0000 + 32'(code) * 32'h0001_0000;
  endfunction

  // Reference model: packet word list from the format rules.
  task automatic expect_pkt(int kind);
    logic [31:0] w[$];
    beat_t b;
    logic light;
    light = 1'b0;
`ifdef UDT_LIGHT_ACK_EN
    light = ack_light;
`endif
    case (kind)
      K_HS:   w = '{ctl_word0(0), 32'h0, timestamp, dst_sock_id};
      K_KA:   w = '{ctl_word0(1), 32'h0, timestamp, dst_sock_id};
      K_ACK:  w = '{ctl_word0(2), ack_seq_no, timestamp, dst_sock_id};
      K_NAK:  w = '{ctl_word0(3), 32'h0, timestamp, dst_sock_id};
      K_ACK2: w = '{ctl_word0(6), ack_seq_no, timestamp, dst_sock_id};
      default: w = '{{1'b0, seq_no}, {msg_ctl, msg_no}, timestamp, dst_sock_id};
    endcase
    if (kind == K_HS) begin
      for (int k = 0; k < 8; k++) w.push_back(32'(hs_info >> (32 * (7 - k))));
    end else if (kind == K_ACK) begin
      w.push_back(rcv_next_seq);
      if (!light) begin
        w.push_back(rtt); w.push_back(rtt_var); w.push_back(avail_buf);
      end
    end else if (kind == K_NAK) begin
      if (nak_first == nak_last) begin
        w.push_back({1'b0, nak_first});
      end else begin
        w.push_back({1'b1, nak_first});
        w.push_back({1'b0, nak_last});
      end
    end
    for (int i = 0; i < w.size(); i++) begin
      b.d = w[i]; b.k = 4'hF;
      b.l = (kind != K_DATA) && (i == w.size() - 1);
      exp_q.push_back(b);
    end
    if (kind == K_DATA) begin
      for (int i = 0; i < pay_n; i++) begin
        b.d = pay_d[i]; b.k = pay_k[i]; b.l = (i == pay_n - 1);
        exp_q.push_back(b);
      end
    end
    exp_ack_q.push_back(ack_bit(kind));
  endtask

  task automatic set_req(int kind, logic v);
    case (kind)
      K_HS:    Handshake_req = v;
      K_KA:    Keep_live_req = v;
      K_ACK:   ACK_req = v;
      K_NAK:   NAK_req = v;
      K_ACK2:  ACK2_req = v;
      default: Data_req = v;
    endcase
  endtask

  task automatic rand_fields();
    timestamp = $urandom; dst_sock_id = $urandom;
    seq_no = 31'($urandom); msg_ctl = 3'($urandom); msg_no = 29'($urandom);
    ack_seq_no = $urandom; rcv_next_seq = $urandom; rtt = $urandom;
    rtt_var = $urandom; avail_buf = $urandom;
    nak_first = 31'($urandom);
    nak_last = ($urandom_range(0, 1) == 0) ? nak_first : 31'($urandom);
    for (int k = 0; k < 8; k++) hs_info[32*k +: 32] = $urandom;
`ifdef UDT_LIGHT_ACK_EN
    ack_light = 1'($urandom_range(0, 1));
`endif
  endtask

  task automatic rand_payload(int n);
    pay_n = n;
    for (int i = 0; i < 8; i++) begin
      pay_d[i] = $urandom;
      pay_k[i] = 4'($urandom);
    end
  endtask

  // Wait (bounded) for the kind's ack, then drop its request after the ack.
  task automatic wait_ack(int kind);
    int n;
    n = 0;
    do begin
      @(negedge core_clk);
      n++;
    end while (((w_acks & ack_bit(kind)) == 6'b0) && n < 3000);
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL ack_timeout: kind %0d got no ack, expected one", kind);
    end
    @(posedge core_clk); #1;
    set_req(kind, 1'b0);
  endtask

  task automatic drive_payload();
    int i, guard;
    bit acc;
    i = 0; guard = 0;
    in_tdata = pay_d[0]; in_tkeep = pay_k[0]; in_tlast = (pay_n == 1); in_tvalid = 1'b1;
    while (i < pay_n && guard < 3000) begin
      @(negedge core_clk);
      guard++;
      acc = in_tvalid && in_tready;
      @(posedge core_clk); #1;
      if (acc) begin
        i++;
        if (i < pay_n) begin
          in_tdata = pay_d[i]; in_tkeep = pay_k[i]; in_tlast = (i == pay_n - 1);
          in_tvalid = ($urandom_range(0, 3) != 0);
        end else begin
          in_tvalid = 1'b0; in_tlast = 1'b0;
        end
      end else begin
        in_tvalid = 1'b1;
      end
    end
    check("payload_drained", 32'(i), 32'(pay_n));
  endtask

  task automatic scramble_after_grant();
    int n;
    n = 0;
    do begin
      @(negedge core_clk);
      n++;
    end while (!out_tvalid && n < 200);
    rand_fields();
  endtask

  task automatic send(int kind, bit scramble);
    expect_pkt(kind);
    pkt_beats = 0;
    set_req(kind, 1'b1);
    fork
      wait_ack(kind);
      begin if (kind == K_DATA) drive_payload(); end
      begin if (scramble) scramble_after_grant(); end
    join
  endtask

  // out_tready pattern generator.
  initial begin
    out_tready = 1'b1;
    forever begin
      @(posedge core_clk); #1;
      case (rdy_mode)
        0: out_tready = 1'b1;
        1: out_tready = ~out_tready;
        default: out_tready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor: beat scoreboard, stall stability, ack timing.
  initial begin
    bit prev_stall, ack_due;
    logic [31:0] sd;
    logic [3:0] sk;
    logic sl;
    logic [5:0] ea;
    beat_t e;
    prev_stall = 0; ack_due = 0; sd = 32'h0; sk = 4'h0; sl = 1'b0;
    forever begin
      @(negedge core_clk);
      if (!core_rst_n) begin
        prev_stall = 0; ack_due = 0;
      end else begin
        if (ack_due) begin
          checks++;
          ea = (exp_ack_q.size() > 0) ? exp_ack_q.pop_front() : 6'b0;
          if (w_acks !== ea) begin
            errors++;
            $display("FAIL ack_pulse: got %b expected %b", w_acks, ea);
          end
          ack_due = 0;
        end else if (w_acks != 6'b0) begin
          checks++; errors++;
          $display("FAIL stray_ack: got %b expected 000000", w_acks);
        end
        if (prev_stall) begin
          checks++;
          if (!out_tvalid || out_tdata !== sd || out_tkeep !== sk || out_tlast !== sl) begin
            errors++;
            $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b expected v=1 d=%h k=%h l=%b",
                     out_tvalid, out_tdata, out_tkeep, out_tlast, sd, sk, sl);
          end
        end
        if (out_tvalid && out_tready) begin
          checks++;
          pkt_beats++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL beat_extra: got d=%h expected no beat", out_tdata);
          end else begin
            e = exp_q.pop_front();
            if (out_tdata !== e.d || out_tkeep !== e.k || out_tlast !== e.l) begin
              errors++;
              $display("FAIL beat: got d=%h k=%h l=%b expected d=%h k=%h l=%b",
                       out_tdata, out_tkeep, out_tlast, e.d, e.k, e.l);
            end
          end
          if (out_tlast) ack_due = 1;
        end
        prev_stall = out_tvalid && !out_tready;
        sd = out_tdata; sk = out_tkeep; sl = out_tlast;
      end
    end
  end

  initial begin
    int n;
    core_rst_n = 1'b0;
    Data_req = 0; ACK_req = 0; ACK2_req = 0; NAK_req = 0; Keep_live_req = 0; Handshake_req = 0;
    in_tdata = 32'h0; in_tkeep = 4'h0; in_tvalid = 1'b0; in_tlast = 1'b0;
    rand_fields();
`ifdef UDT_LIGHT_ACK_EN
    ack_light = 1'b0;
`endif
    rand_payload(1);

    #17;
    check("rst_tvalid", 32'(out_tvalid), 32'h0);
    check("rst_tlast", 32'(out_tlast), 32'h0);
    check("rst_in_tready", 32'(in_tready), 32'h0);
    check("rst_acks", 32'(w_acks), 32'h0);
    check("rst_tdata", out_tdata, 32'h0);
    check("rst_tkeep", 32'(out_tkeep), 32'h0);
    core_rst_n = 1'b1;
    @(posedge core_clk); #1;

    // Keep-alive
    rdy_mode = 0;
    timestamp = 32'h100; dst_sock_id = 32'h55;
    send(K_KA, 0);
    check("ka_beats", 32'(pkt_beats), 32'd4);

    // NAK single, then range
    nak_first = 31'h10; nak_last = 31'h10;
    send(K_NAK, 0);
    check("nak1_beats", 32'(pkt_beats), 32'd5);
    nak_last = 31'h20;
    send(K_NAK, 0);
    check("nak2_beats", 32'(pkt_beats), 32'd6);

    // Data with toggling back-pressure
    rdy_mode = 1;
    seq_no = 31'd7; msg_ctl = 3'b110; msg_no = 29'd1;
    rand_payload(3);
    send(K_DATA, 0);
    check("data_beats", 32'(pkt_beats), 32'd7);

    // Simultaneous ACK + Data: ACK first, 2-cycle gap, then data
    rdy_mode = 0;
    rand_fields();
`ifdef UDT_LIGHT_ACK_EN
    ack_light = 1'b0;
`endif
    rand_payload(2);
    expect_pkt(K_ACK);
    expect_pkt(K_DATA);
    pkt_beats = 0;
    set_req(K_ACK, 1'b1);
    set_req(K_DATA, 1'b1);
    fork
      begin
        wait_ack(K_ACK);
        @(negedge core_clk);
        check("gap_idle_valid", 32'(out_tvalid), 32'h0);
        @(negedge core_clk);
        check("gap_hdr_valid", 32'(out_tvalid), 32'h1);
        check("gap_hdr_word", out_tdata, {1'b0, seq_no});
        wait_ack(K_DATA);
      end
      drive_payload();
    join
    check("simul_beats", 32'(pkt_beats), 32'd14);

    // Handshake interrupted by reset, then restarted by the held request
    rand_fields();
    expect_pkt(K_HS);
    pkt_beats = 0;
    set_req(K_HS, 1'b1);
    n = 0;
    while (pkt_beats < 7 && n < 200) begin
      @(negedge core_clk);
      n++;
    end
    check("hs_reached_word3", 32'(pkt_beats >= 7), 32'h1);
    #1 core_rst_n = 1'b0;
    #1;
    check("midrst_tvalid", 32'(out_tvalid), 32'h0);
    check("midrst_hs_ack", 32'(Handshake_ack), 32'h0);
    exp_q.delete();
    exp_ack_q.delete();
    @(negedge core_clk);
    @(negedge core_clk);
    #1 core_rst_n = 1'b1;
    pkt_beats = 0;
    expect_pkt(K_HS);
    wait_ack(K_HS);
    check("hs_restart_beats", 32'(pkt_beats), 32'd12);

`ifdef UDT_LIGHT_ACK_EN
    rand_fields();
    ack_light = 1'b1; rcv_next_seq = 32'h44;
    send(K_ACK, 0);
    check("light_ack_beats", 32'(pkt_beats), 32'd5);
`endif

    // Randomized packets with random back-pressure; fields scrambled after grant
    rdy_mode = 2;
    for (int t = 0; t < 40; t++) begin
      int kind;
      kind = $urandom_range(0, 5);
      rand_fields();
      rand_payload($urandom_range(1, 5));
      send(kind, 1);
    end

    repeat (5) @(negedge core_clk);
    check("beats_left", 32'(exp_q.size()), 32'h0);
    check("acks_left", 32'(exp_ack_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encode.md
# encode

Transmit-side UDT packet builder: turns request/field strobes from the ACK, NAK, keep-alive, handshake and sender logic into UDT control and data packets on an AXI-Stream toward the UDP layer. It is the peer of the receive-side decoder. It arbitrates among pending packet requests and emits one packet at a time: a 4-word header, then control information or the payload streamed from the sender buffer.

## Interface
- `C_S_AXI_DATA_WIDTH`, 32: stream width. Only 32 is supported, so one UDT word is one beat.
- `core_clk` in 1: clock.
- `core_rst_n` in 1: asynchronous, active-low reset.
- `timestamp` in 32: microsecond time, sampled at grant.
- `dst_sock_id` in 32: peer socket ID, sampled at grant.
- `Data_req`/`Data_ack` in/out 1: data packet request and done pulse.
- `seq_no` in 31; `msg_ctl` in 3 (`{ff[1:0], in_order}`); `msg_no` in 29: data header fields.
- `in_tdata` in 32, `in_tkeep` in 4, `in_tvalid` in 1, `in_tready` out 1, `in_tlast` in 1: payload stream.
- `ACK_req`/`ACK_ack`; `ack_seq_no` in 32; `rcv_next_seq` in 32, `rtt` in 32, `rtt_var` in 32, `avail_buf` in 32: ACK fields.
- `ACK2_req`/`ACK2_ack`: ACK2 uses `ack_seq_no`.
- `NAK_req`/`NAK_ack`; `nak_first` in 31, `nak_last` in 31: loss range.
- `Keep_live_req`/`Keep_live_ack`: keep-alive request.
- `Handshake_req`/`Handshake_ack`; `hs_info` in 256: eight handshake words, MSB word first.
- `out_tdata` out 32, `out_tkeep` out 4, `out_tvalid` out 1, `out_tlast` out 1, `out_tready` in 1: UDP payload out.

## Operation
- FSM states: IDLE, HDR, BODY, PAYLOAD, DONE.
- **IDLE arbitration**, fixed priority: Handshake > ACK2 > ACK > NAK > Keep_live > Data. The grant latches every field of the winner into registers. Inputs may change after the grant.
- **HDR** emits 4 beats.
  - Control packet: `{1'b1, type[14:0], 16'h0000}`, then additional info, then timestamp, then `dst_sock_id`.
  - Type codes: Handshake 0, Keep_live 1, ACK 2, NAK 3, ACK2 6.
  - Additional info is `ack_seq_no` for ACK and ACK2, and 0 for all other types.
  - Data packet: `{1'b0, seq_no}`, then `{msg_ctl, msg_no}`, then timestamp, then `dst_sock_id`.
- **BODY** emits the control information:
  - ACK: `rcv_next_seq`, `rtt`, `rtt_var`, `avail_buf` (4 words).
  - NAK with `nak_first == nak_last`: one word, `{1'b0, nak_first}`.
  - NAK range: two words, `{1'b1, nak_first}` then `{1'b0, nak_last}`.
  - Handshake: 8 words.
  - Keep_live and ACK2 have no body; `out_tlast` goes on header beat 4.
- **PAYLOAD** (data packets only):
  - Combinational pass-through with `in_tready = out_tready`, `in_tvalid` mapped to `out_tvalid`, and tdata/tkeep/tlast passed directly.
  - The state ends on the accepted beat with `in_tlast`.
- **DONE** lasts one cycle. The granted `*_ack` pulses high for exactly this cycle, then the FSM returns to IDLE.
- **Requester rule:** a requester holds `*_req` until its ack and drops it in the cycle after the ack. A request still high in IDLE starts a new packet.
- **`out_tkeep`** is 4'hF on header and body beats; in PAYLOAD it equals `in_tkeep`.

## Timing
- **Reset values:**
  - Outputs: `out_tvalid`, `out_tlast`, `in_tready` and all `*_ack` are 0; `out_tdata` and `out_tkeep` are 0.
  - FSM is in IDLE.
  - A reset mid-packet truncates the packet with no `out_tlast` and no ack.
- **Grant latency:** the grant occurs in IDLE cycle N, and the first header beat is valid at N+1.
- **Beat rate:** one beat per cycle while `out_tready` = 1.
- **Hold rule (header/body):** while `out_tvalid && !out_tready`, `out_tdata`, `out_tkeep` and `out_tlast` stay stable.
- **Back-to-back:** the minimum gap between packets is 2 cycles (DONE + IDLE).
- **Empty payload:** a data packet whose first payload beat carries `in_tlast` gives 5 beats total.
- **Simultaneous requests:** only the highest-priority request is served. The others stay pending and receive no ack.
- **NAK width:** `nak_first`/`nak_last` compare on the full 31 bits.

## Configuration
- Macro: `UDT_LIGHT_ACK_EN`.
- **Defined:**
  - Adds input `ack_light` (1), sampled at the ACK grant.
  - If `ack_light` is 1, the ACK body is `rcv_next_seq` only, so the packet is 5 beats.
  - If `ack_light` is 0, the full 4-word body is sent.
- **Undefined:** the port is absent and every ACK is 8 beats.

## Test plan
- **Keep_live:** `Keep_live_req` with `timestamp` = 0x100, `dst_sock_id` = 0x55, `out_tready` = 1 → beats 0x80010000, 0, 0x100, 0x55; `out_tlast` on beat 4; `Keep_live_ack` pulses 1 cycle later.
- **NAK, single and range:** `nak_first` = `nak_last` = 0x10 → 5 beats, last 0x00000010. Then `nak_first` = 0x10, `nak_last` = 0x20 → 6 beats ending 0x80000010, 0x00000020.
- **Data with back-pressure:** `seq_no` = 7, `msg_ctl` = 3'b110, `msg_no` = 1, 3-beat payload, `out_tready` toggling every cycle → header 0x00000007, 0xC0000001, then the payload unchanged; outputs stable during stalls; `Data_ack` after the third beat.
- **Simultaneous requests:** ACK and Data raised in the same cycle → ACK (type 0x8002) is sent first, then the data packet. No beats interleave.
- **Reset mid-packet:** assert `core_rst_n` = 0 during handshake word 3 → `out_tvalid` = 0 immediately and no `Handshake_ack`. After release, the held request restarts the full 12-beat packet.
- **`UDT_LIGHT_ACK_EN` defined:** `ack_light` = 1, `rcv_next_seq` = 0x44 → 5 beats, last 0x44, `out_tlast` on beat 5.
